// File: rtl/intra_recon_pkg.sv
// Shared definitions for intra reconstruction: TU mode encoding, beats-per-TU
// arithmetic and the sample clipping helper.
package intra_recon_pkg;

  typedef enum logic [1:0] {
    MODE_PRED = 2'd0,
    MODE_RESI = 2'd1,
    MODE_PCM  = 2'd2
  } recon_mode_e;

  localparam int CLIP_W = 16;

  // PCM wins over the residual flag.
  function automatic recon_mode_e decode_mode(input logic has_resi, input logic is_pcm);
    if (is_pcm) return MODE_PCM;
    if (has_resi) return MODE_RESI;
    return MODE_PRED;
  endfunction

  function automatic logic [10:0] beats_per_tu(input logic [2:0] size_log2, input int nsamp_log2);
    logic [10:0] samples;
    samples = 11'd1 << {size_log2, 1'b0};
    return samples >> nsamp_log2;
  endfunction

  function automatic logic [CLIP_W-1:0] clip_pixel(input logic signed [CLIP_W-1:0] val,
                                                   input logic [3:0] bit_depth);
    logic signed [CLIP_W-1:0] max_val;
    max_val = $signed((CLIP_W'(1) << bit_depth) - CLIP_W'(1));
    if (val < 0) return '0;
    if (val > max_val) return max_val;
    return val;
  endfunction

endpackage

// File: rtl/intra_recon_fifo.sv
// Output FIFO with registered read data; a pushed word is presented on the
// cycle after the push, including the write-through case into an empty FIFO.
module intra_recon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] rd_data_reg, rd_data_next;
  logic             push_ok, pop_ok;

  assign push_ok     = push && (count_reg != FULL_CNT);
  assign pop_ok      = pop && (count_reg != '0);
  assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop_ok);

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // The head register follows the next read pointer; bypass when that slot is
  // being written this same cycle.
  always_comb begin
    rd_data_next = mem[rd_ptr_next];
    if (push_ok && (wr_ptr_reg == rd_ptr_next)) rd_data_next = push_data;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      rd_data_reg <= rd_data_next;
    end
  end

  assign rd_data = rd_data_reg;
  assign count   = count_reg;
  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);

endmodule

// File: rtl/intra_recon_join.sv
// Joins prediction and residual beats into reconstructed samples, one TU
// command at a time, buffering the result in a small output FIFO.
module intra_recon_join
  import intra_recon_pkg::*;
#(
  parameter int BDEPTH     = 10,
  parameter int NSAMP      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic [3:0]                  gp_bitDepth,
  input  logic                        tu_val,
  output logic                        tu_rdy,
  input  logic [2:0]                  tuSizeLog2,
  input  logic                        has_resi,
  input  logic                        isPcm,
  input  logic [3:0]                  pcm_shift,
  input  logic [BDEPTH*NSAMP-1:0]     predSamples,
  input  logic                        pred_val,
  output logic                        pred_rdy,
  input  logic [(BDEPTH+1)*NSAMP-1:0] residuals,
  input  logic                        resi_val,
  output logic                        resi_rdy,
  output logic [BDEPTH*NSAMP-1:0]     r_reconSamples,
  output logic                        recon_val,
  input  logic                        recon_rdy,
  output logic                        recon_last
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int NSAMP_LOG2 = $clog2(NSAMP);
  localparam int DATA_W     = BDEPTH * NSAMP;
  localparam int CNT_W      = 8;
  localparam int SW         = BDEPTH + 15;
  localparam int FCNT_W     = $clog2(FIFO_DEPTH+1);

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
  recon_mode_e      mode_reg, mode_next;
  logic [3:0]       pcm_shift_reg, pcm_shift_next;

  logic              consume, fire, last_beat, idle_or_done, accept;
  logic [DATA_W-1:0] recon_bus;
  logic [SW-1:0]     pix_max;
  logic [DATA_W:0]   fifo_rd_data;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full, fifo_empty;

  assign consume = (mode_reg == MODE_RESI);
  // Only the registered full flag gates a fire, so recon_rdy never reaches pred_rdy.
  assign fire = (state_reg == ST_RUN) && pred_val && !fifo_full && (resi_val || !consume);
  assign last_beat    = fire && (beat_cnt_reg == '0);
  assign idle_or_done = (state_reg == ST_IDLE) || last_beat;
  assign tu_rdy       = arst_n && idle_or_done;
  assign accept       = tu_val && tu_rdy;
  assign pred_rdy     = fire;
  assign resi_rdy     = fire && consume;

  always_comb begin
    state_next     = state_reg;
    beat_cnt_next  = beat_cnt_reg;
    mode_next      = mode_reg;
    pcm_shift_next = pcm_shift_reg;
    if (accept) begin
      state_next     = ST_RUN;
      beat_cnt_next  = CNT_W'(beats_per_tu(tuSizeLog2, NSAMP_LOG2) - 11'd1);
      mode_next      = decode_mode(has_resi, isPcm);
      pcm_shift_next = pcm_shift;
    end else if (last_beat) begin
      state_next = ST_IDLE;
    end else if (fire) begin
      beat_cnt_next = beat_cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg     <= ST_IDLE;
      beat_cnt_reg  <= '0;
      mode_reg      <= MODE_PRED;
      pcm_shift_reg <= '0;
    end else begin
      state_reg     <= state_next;
      beat_cnt_reg  <= beat_cnt_next;
      mode_reg      <= mode_next;
      pcm_shift_reg <= pcm_shift_next;
    end
  end

  assign pix_max = (SW'(1) << gp_bitDepth) - SW'(1);

  generate
    for (genvar gi = 0; gi < NSAMP; gi++) begin : g_samp
      logic        [BDEPTH-1:0] pred_s;
      logic signed [BDEPTH:0]   res_s;
      logic signed [BDEPTH+1:0] sum_s;
      logic        [SW-1:0]     shifted_s;
      logic        [BDEPTH-1:0] recon_s;

      assign pred_s    = predSamples[(NSAMP-1-gi)*BDEPTH +: BDEPTH];
      assign res_s     = residuals[(NSAMP-1-gi)*(BDEPTH+1) +: BDEPTH+1];
      assign sum_s     = $signed({2'b00, pred_s}) + $signed({res_s[BDEPTH], res_s});
      assign shifted_s = SW'(pred_s) << pcm_shift_reg;

      always_comb begin
        recon_s = pred_s;
        case (mode_reg)
          MODE_PCM:  recon_s = (shifted_s > pix_max) ? pix_max[BDEPTH-1:0] : shifted_s[BDEPTH-1:0];
          MODE_RESI: recon_s = BDEPTH'(clip_pixel(
                         $signed({{(CLIP_W-BDEPTH-2){sum_s[BDEPTH+1]}}, sum_s}), gp_bitDepth));
          default:   recon_s = pred_s;
        endcase
      end

      assign recon_bus[(NSAMP-1-gi)*BDEPTH +: BDEPTH] = recon_s;
    end
  endgenerate

  intra_recon_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (fire),
    .push_data ({recon_bus, last_beat}),
    .pop       (recon_val && recon_rdy),
    .rd_data   (fifo_rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign recon_val      = (fifo_count != '0);
  assign r_reconSamples = fifo_rd_data[DATA_W:1];
  assign recon_last     = fifo_rd_data[0] && !fifo_empty;

endmodule

// File: doc/intra_recon_join.md
INTRA_RECON_JOIN -- requirements
Module: intra_recon_join

Interface
REQ-001 SHALL have parameter BDEPTH, default 10: maximum sample bit depth (8..12).
REQ-002 SHALL have parameter NSAMP, default 16: samples per beat (4, 8 or 16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries (power of 2, >=2).
REQ-004 SHALL have ports: clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have ports: arst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: gp_bitDepth  in  4  runtime bit depth, 8..BDEPTH, static while not idle.
REQ-007 SHALL have ports: tu_val / tu_rdy  in / out  1 / 1  TU command handshake.
REQ-008 SHALL have ports: tuSizeLog2  in  3  TU size log2, 2..5.
REQ-009 SHALL have ports: has_resi  in  1  1 = residual stream consumed; 0 = recon equals pred.
REQ-010 SHALL have ports: isPcm  in  1  PCM TU; residual not consumed; pred path carries PCM samples.
REQ-011 SHALL have ports: pcm_shift  in  4  left shift applied to PCM samples.
REQ-012 SHALL have ports: predSamples / pred_val / pred_rdy  in / in / out  BDEPTH*NSAMP / 1 / 1  prediction beat.
REQ-013 SHALL have ports: residuals / resi_val / resi_rdy  in / in / out  (BDEPTH+1)*NSAMP / 1 / 1  signed residual beat.
REQ-014 SHALL have ports: r_reconSamples / recon_val / recon_rdy / recon_last  out / out / in / out  BDEPTH*NSAMP / 1 / 1 / 1  reconstructed beat; last flags final beat of TU.
REQ-015 SHALL pack sample 0 in the most-significant field of every bus.

Function
REQ-016 SHALL use a state machine with states IDLE and RUN.
REQ-017 SHALL drive tu_rdy = IDLE, or RUN with the last beat firing that cycle.
REQ-018 SHALL latch tuSizeLog2, has_resi, isPcm and pcm_shift on tu_val&&tu_rdy, then enter RUN.
REQ-019 SHALL load the beat counter with (1<<(2*tuSizeLog2))/NSAMP - 1 on command accept.
REQ-020 SHALL fire a beat when state is RUN, pred_val=1, FIFO count < FIFO_DEPTH, and (resi_val=1 or residual not consumed).
REQ-021 SHALL assert pred_rdy, and resi_rdy when the residual is consumed, only in the firing cycle; the residual is consumed iff has_resi=1 and isPcm=0.
REQ-022 SHALL compute per sample: normal recon = clip(pred + res, 0, 2^gp_bitDepth-1), summed at BDEPTH+2 signed bits.
REQ-023 SHALL compute per sample: has_resi=0 and isPcm=0 gives recon = pred.
REQ-024 SHALL compute per sample: isPcm=1 gives recon = pred << pcm_shift, saturated to 2^gp_bitDepth-1; isPcm overrides has_resi.
REQ-025 SHALL push on fire and decrement the counter; at counter 0 it SHALL set recon_last on that entry and leave RUN.
REQ-026 SHALL return to IDLE after the last beat, or stay in RUN if a new command is accepted in the same cycle.
REQ-027 SHALL make a pushed beat visible at r_reconSamples/recon_val on the next cycle (latency 1).
REQ-028 SHALL pop on recon_val&&recon_rdy; push and pop in the same cycle SHALL leave count unchanged.
REQ-029 SHALL NOT fire when count == FIFO_DEPTH, even if a pop occurs in the same cycle; there SHALL be no combinational path from recon_rdy to pred_rdy or resi_rdy.
REQ-030 SHALL make r_reconSamples don't-care when recon_val=0; a beat SHALL be held stable until popped.
REQ-031 SHALL keep input data unobserved when neither fire nor command accept occurs.

Reset
REQ-032 SHALL, on arst_n low: state IDLE, counter 0, FIFO empty, recon_val=0, recon_last=0, pred_rdy=0, resi_rdy=0, tu_rdy=0 while in reset.
REQ-033 SHALL discard all in-flight beats and the latched command on reset mid-TU; tu_rdy SHALL be 1 on the first cycle after release.

Structure
REQ-034 SHALL place mode encodings, the beats-per-TU function and the clip function in shared package intra_recon_pkg.
REQ-035 SHALL instantiate the output FIFO as sub-module intra_recon_fifo (count, full, empty, registered read data).

Verification
REQ-036 SHALL test: BDEPTH=10, NSAMP=16, 4x4 normal, pred all 1020, res all +10, gp_bitDepth=10 -> one beat, all samples 1023, recon_last=1.
REQ-037 SHALL test: pred 5, res -9 -> recon 0; pred 200, res +100, gp_bitDepth=8 -> recon 255.
REQ-038 SHALL test: 32x32 TU, has_resi=0, NSAMP=16 -> 64 beats equal to pred, resi_rdy never 1, recon_last only on beat 64.
REQ-039 SHALL test: isPcm=1, pcm_shift=2, pred 100, gp_bitDepth=10 -> recon 400, with residual stream untouched.
REQ-040 SHALL test: recon_rdy=0 for 20 cycles -> exactly FIFO_DEPTH beats accepted, then pred_rdy=0; after release, order preserved with no loss.
REQ-041 SHALL test: arst_n asserted mid-way through a 16x16 TU -> recon_val=0 next cycle, tu_rdy=1 after release, next TU reconstructs correctly.
